// File: rtl/dieu_khien_bom_xa_if.sv
// -----------------------------------------------------------------------------
// dieu_khien_bom_xa_if
// Bundles the control/sensor inputs and the drive/status outputs of the
// pump/discharge sequencer.
//   master : the controlling side (host/bench). It drives the enable, the sensors,
//            the target and the fault acknowledge, and it observes the status.
//   slave  : the sequencer itself.
// Signals
//   en, muc_thap, muc_cao, xa_in, vol_target[15:0], clr_fault : to sequencer
//   bom, van_xa, state[2:0], vol_count[15:0], done, fault,
//   fault_code[1:0]                                           : from sequencer
// -----------------------------------------------------------------------------
interface dieu_khien_bom_xa_if;
    logic        en;
    logic        muc_thap;
    logic        muc_cao;
    logic        xa_in;
    logic [15:0] vol_target;
    logic        clr_fault;
    logic        bom;
    logic        van_xa;
    logic [2:0]  state;
    logic [15:0] vol_count;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        output en, muc_thap, muc_cao, xa_in, vol_target, clr_fault,
        input  bom, van_xa, state, vol_count, done, fault, fault_code
    );

    modport slave (
        input  en, muc_thap, muc_cao, xa_in, vol_target, clr_fault,
        output bom, van_xa, state, vol_count, done, fault, fault_code
    );
endinterface

// File: rtl/dieu_khien_bom_xa.sv
// -----------------------------------------------------------------------------
// dieu_khien_bom_xa
// Pump/discharge sequencer. The pump fills the tank until the high-level
// sensor trips. The discharge valve then opens. The block counts edges from the
// discharge pulse sensor until the target volume is reached or the tank reads
// low. It enforces minimum run and rest times. It latches faults for a fill
// timeout, a dry discharge and conflicting level sensors.
// Ports
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : dieu_khien_bom_xa_if.slave (sensors/commands in, drives/status out)
// -----------------------------------------------------------------------------
module dieu_khien_bom_xa #(
    parameter int MIN_RUN      = 1000,
    parameter int MIN_REST     = 1000,
    parameter int FILL_TIMEOUT = 1000000,
    parameter int DRY_TIMEOUT  = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    dieu_khien_bom_xa_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRAIN = 3'd2,
        S_REST  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [23:0] RUN_LIM  = 24'(MIN_RUN - 1);
    localparam logic [23:0] REST_LIM = 24'(MIN_REST - 1);
    localparam logic [23:0] FILL_LIM = 24'(FILL_TIMEOUT - 1);
    localparam logic [23:0] DRY_LIM  = 24'(DRY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [23:0] timer_q;
    logic        xa_s1_q, xa_s2_q, xa_prev_q;
    logic [15:0] target_q;
    logic [15:0] vol_count_q;
    logic [1:0]  code_q, code_d;
    logic        bom_q, bom_d;
    logic        van_q, van_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic        edge_s;
    logic        conflict_s;
    logic [15:0] cnt_next_s;
    logic        hit_s;
    logic        drain_done_s;

    // Discharge edge strobe. It lasts one cycle, after synchronization.
    assign edge_s     = xa_s2_q & ~xa_prev_q;
    assign conflict_s = bus.muc_cao & bus.muc_thap;
    // This is the count including this cycle's edge. The target compare uses it,
    // so an edge that lands on the target is counted before the exit.
    assign cnt_next_s = (edge_s && (vol_count_q != 16'hFFFF)) ? vol_count_q + 16'd1
                                                              : vol_count_q;
    assign hit_s      = (target_q != 16'd0) && (cnt_next_s == target_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and fault-code selection. A sensor conflict overrides every other transition.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        drain_done_s = 1'b0;
        if ((state_q != S_FAULT) && conflict_s) begin
            state_d = S_FAULT;
            code_d  = 2'b11;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.en) begin
                        state_d = bus.muc_cao ? S_DRAIN : S_FILL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FILL: begin
                    if (!bus.en) begin
                        state_d = S_REST;
                    end else if (bus.muc_cao && (timer_q >= RUN_LIM)) begin
                        state_d = S_DRAIN;
                    end else if (timer_q == FILL_LIM) begin
                        state_d = S_FAULT;
                        code_d  = 2'b01;
                    end else begin
                        state_d = S_FILL;
                    end
                end
                S_DRAIN: begin
                    if (bus.muc_thap || hit_s) begin
                        state_d      = S_REST;
                        drain_done_s = 1'b1;
                    end else if (!bus.en) begin
                        state_d = S_REST;
                    end else if (!edge_s && (timer_q == DRY_LIM)) begin
                        state_d = S_FAULT;
                        code_d  = 2'b10;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_REST: begin
                    if (timer_q == REST_LIM) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REST;
                    end
                end
                S_FAULT: begin
                    if (bus.clr_fault && !conflict_s) begin
                        state_d = S_IDLE;
                        code_d  = 2'b00;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    code_d  = 2'b00;
                end
            endcase
        end
    end

    // Drive/status decode from the next state. The outputs register with the state.
    always_comb begin
        bom_d   = (state_d == S_FILL);
        van_d   = (state_d == S_DRAIN);
        fault_d = (state_d == S_FAULT);
        done_d  = drain_done_s;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bom_q   <= 1'b0;
            van_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            bom_q   <= bom_d;
            van_q   <= van_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    // Two-flop synchronizer on xa_in, plus the previous-value register for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            xa_s1_q   <= 1'b0;
            xa_s2_q   <= 1'b0;
            xa_prev_q <= 1'b0;
        end else begin
            xa_s1_q   <= bus.xa_in;
            xa_s2_q   <= xa_s1_q;
            xa_prev_q <= xa_s2_q;
        end
    end

    // State timer. It restarts on every state change and on each counted discharge edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 24'd0;
        end else if (state_d != state_q) begin
            timer_q <= 24'd0;
        end else if ((state_q == S_DRAIN) && edge_s) begin
            timer_q <= 24'd0;
        end else if (timer_q != 24'hFF_FFFF) begin
            timer_q <= timer_q + 24'd1;
        end else begin
            timer_q <= timer_q;
        end
    end

    // Volume counter and target latch. The counter holds its value outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q    <= 16'd0;
            vol_count_q <= 16'd0;
        end else if ((state_q != S_DRAIN) && (state_d == S_DRAIN)) begin
            target_q    <= bus.vol_target;
            vol_count_q <= 16'd0;
        end else if (state_q == S_DRAIN) begin
            target_q    <= target_q;
            vol_count_q <= cnt_next_s;
        end else begin
            target_q    <= target_q;
            vol_count_q <= vol_count_q;
        end
    end

    assign bus.bom        = bom_q;
    assign bus.van_xa     = van_q;
    assign bus.state      = state_q;
    assign bus.vol_count  = vol_count_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule

// File: tb/tb_dieu_khien_bom_xa.sv
// -----------------------------------------------------------------------------
// tb_dieu_khien_bom_xa
// Self-checking bench for the pump/discharge sequencer. It uses small timing
// parameters:
//   MIN_RUN=4, MIN_REST=3, FILL_TIMEOUT=20, DRY_TIMEOUT=10.
// A table of single-cycle vectors covers the minimum run, a reset mid-DRAIN
// and dropping enable in FILL. Hand-written sequences cover the multi-cycle
// scenarios.
// -----------------------------------------------------------------------------
module tb_dieu_khien_bom_xa;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dieu_khien_bom_xa_if bus_if ();

    dieu_khien_bom_xa #(
        .MIN_RUN      (4),
        .MIN_REST     (3),
        .FILL_TIMEOUT (20),
        .DRY_TIMEOUT  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        cao;
        logic        thap;
        logic        xa;
        logic        clr;
        logic [15:0] tgt;
        logic [2:0]  e_st;
        logic        e_bom;
        logic        e_van;
        logic        e_done;
        logic        e_fault;
        logic [1:0]  e_code;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    // Interlock: the pump and the valve are never driven together.
    always @(negedge clk) begin
        checks++;
        if ((bus_if.bom & bus_if.van_xa) === 1'b1) begin
            errors++;
            $display("FAIL interlock bom=%0b van_xa=%0b required not both 1", bus_if.bom, bus_if.van_xa);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic [2:0] st, input logic b,
                              input logic v, input logic d, input logic f,
                              input logic [1:0] c, input logic [15:0] cnt);
        chk({nm, " state"},      32'(bus_if.state),      32'(st));
        chk({nm, " bom"},        32'(bus_if.bom),        32'(b));
        chk({nm, " van_xa"},     32'(bus_if.van_xa),     32'(v));
        chk({nm, " done"},       32'(bus_if.done),       32'(d));
        chk({nm, " fault"},      32'(bus_if.fault),      32'(f));
        chk({nm, " fault_code"}, 32'(bus_if.fault_code), 32'(c));
        chk({nm, " vol_count"},  32'(bus_if.vol_count),  32'(cnt));
    endtask

    task automatic wait_state(input logic [2:0] st, input int max, input string nm);
        int n;
        n = 0;
        while ((bus_if.state !== st) && (n < max)) begin
            step();
            n++;
        end
        chk(nm, 32'(bus_if.state), 32'(st));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.en         = 1'b0;
        bus_if.muc_thap   = 1'b0;
        bus_if.muc_cao    = 1'b0;
        bus_if.xa_in      = 1'b0;
        bus_if.vol_target = 16'd0;
        bus_if.clr_fault  = 1'b0;

        //            rst   en    cao   thap  xa    clr   tgt     st    bom   van   done  flt   code   cnt
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0};

        // Reset state
        step();
        step();
        rst = 1'b0;
        check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);

        // Table: minimum run, reset mid-DRAIN, en dropped in FILL, REST length
        for (int i = 0; i < NV; i++) begin
            rst               = vecs[i].rst;
            bus_if.en         = vecs[i].en;
            bus_if.muc_cao    = vecs[i].cao;
            bus_if.muc_thap   = vecs[i].thap;
            bus_if.xa_in      = vecs[i].xa;
            bus_if.clr_fault  = vecs[i].clr;
            bus_if.vol_target = vecs[i].tgt;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_bom, vecs[i].e_van,
                       vecs[i].e_done, vecs[i].e_fault, vecs[i].e_code, vecs[i].e_cnt);
        end
        rst = 1'b0;

        // Normal cycle: fill for 10 cycles, drain 5 pulses of period 6
        bus_if.vol_target = 16'd5;
        bus_if.en         = 1'b1;
        bus_if.muc_cao    = 1'b0;
        repeat (10) step();
        check_outs("norm fill", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
        bus_if.muc_cao = 1'b1;
        step();
        check_outs("norm drain entry", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        bus_if.muc_cao = 1'b0;
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 6; j++) begin
                bus_if.xa_in = (j < 3);
                step();
                if (j == 2) begin
                    chk($sformatf("norm cnt p%0d", p), 32'(bus_if.vol_count), 32'(p + 1));
                end
                if ((p < 4) || (j < 2)) begin
                    chk($sformatf("norm drain p%0d j%0d", p, j), 32'(bus_if.state), 32'd2);
                end
            end
            if (p == 3) begin
                chk("norm no early done", 32'(bus_if.done), 32'd0);
            end
        end
        // After the loop, the 5th pulse has been counted at j2. REST then lasts j2..j4 and IDLE is reached at j5.
        chk("norm idle after rest", 32'(bus_if.state), 32'd0);
        chk("norm cnt held", 32'(bus_if.vol_count), 32'd5);
        bus_if.en = 1'b0;
        step();

        // Done pulse timing: replay a short drain with target 1 and observe each cycle
        bus_if.vol_target = 16'd1;
        bus_if.en         = 1'b1;
        bus_if.muc_cao    = 1'b1;
        step();
        check_outs("t1 drain", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd0);
        bus_if.muc_cao = 1'b0;
        bus_if.xa_in   = 1'b1;
        step();
        step();
        chk("t1 before count", 32'(bus_if.state), 32'd2);
        step();
        check_outs("t1 done", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'd1);
        bus_if.xa_in = 1'b0;
        step();
        check_outs("t1 done drop", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd1);
        bus_if.en = 1'b0;
        wait_state(3'd0, 10, "t1 back idle");

        // Fill timeout
        bus_if.en      = 1'b1;
        bus_if.muc_cao = 1'b0;
        step();
        repeat (19) step();
        chk("fto still fill", 32'(bus_if.state), 32'd1);
        step();
        check_outs("fto fault", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'd1);
        bus_if.en        = 1'b0;
        bus_if.clr_fault = 1'b1;
        step();
        check_outs("fto clear", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd1);
        bus_if.clr_fault = 1'b0;

        // Dry discharge: no edges
        bus_if.vol_target = 16'd0;
        bus_if.en         = 1'b1;
        bus_if.muc_cao    = 1'b1;
        step();
        bus_if.muc_cao = 1'b0;
        repeat (9) step();
        chk("dry still drain", 32'(bus_if.state), 32'd2);
        step();
        check_outs("dry fault", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 16'd0);
        bus_if.en        = 1'b0;
        bus_if.clr_fault = 1'b1;
        step();
        bus_if.clr_fault = 1'b0;
        chk("dry clear", 32'(bus_if.state), 32'd0);

        // Dry discharge repeat: one edge every 8 cycles keeps it alive
        bus_if.en      = 1'b1;
        bus_if.muc_cao = 1'b1;
        step();
        bus_if.muc_cao = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus_if.xa_in = ((i % 8) < 4);
            step();
        end
        check_outs("alive drain", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd5);
        bus_if.en = 1'b0;
        step();
        check_outs("en drop drain", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd5);
        wait_state(3'd0, 10, "en drop idle");

        // Sensor conflict during DRAIN
        bus_if.en      = 1'b1;
        bus_if.muc_cao = 1'b1;
        step();
        bus_if.muc_cao = 1'b0;
        step();
        step();
        bus_if.muc_cao  = 1'b1;
        bus_if.muc_thap = 1'b1;
        step();
        check_outs("conflict fault", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'd0);
        bus_if.en        = 1'b0;
        bus_if.clr_fault = 1'b1;
        step();
        check_outs("conflict clr held", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'd0);
        bus_if.muc_thap = 1'b0;
        step();
        check_outs("conflict cleared", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
        bus_if.clr_fault = 1'b0;
        bus_if.muc_cao   = 1'b0;

        // Target 0: drain until muc_thap after 3 edges
        bus_if.vol_target = 16'd0;
        bus_if.en         = 1'b1;
        bus_if.muc_cao    = 1'b1;
        step();
        bus_if.muc_cao = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 6; j++) begin
                bus_if.xa_in = (j < 3);
                step();
            end
        end
        check_outs("low drain", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'd3);
        bus_if.muc_thap = 1'b1;
        step();
        check_outs("low done", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'd3);
        bus_if.muc_thap = 1'b0;
        bus_if.en       = 1'b0;
        step();
        chk("low done drop", 32'(bus_if.done), 32'd0);
        wait_state(3'd0, 10, "low idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
